// File: rtl/pmsm_dq_plant.sv
// PMSM dq-frame plant model for the HIL loop.
// One forward-Euler step per accepted 'step' request. A single shared multiplier is
// time-multiplexed over 13 MAC cycles, then all four state variables commit together.
module pmsm_dq_plant #(
   parameter int unsigned W_ST  = 16,
   parameter int unsigned F_ST  = 12,
   parameter int unsigned W_K   = 18,
   parameter int unsigned F_K   = 16,
   parameter int unsigned W_ANG = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    step,
   input  logic                    lock,
   input  logic signed [W_ST-1:0]  v_d,
   input  logic signed [W_ST-1:0]  v_q,
   input  logic signed [W_ST-1:0]  t_load,
   input  logic signed [W_K-1:0]   k_v,
   input  logic signed [W_K-1:0]   k_r,
   input  logic signed [W_K-1:0]   k_dt,
   input  logic signed [W_K-1:0]   k_e,
   input  logic signed [W_K-1:0]   k_t,
   input  logic signed [W_K-1:0]   k_b,
   input  logic signed [W_K-1:0]   k_j,
   input  logic signed [W_K-1:0]   k_th,
   output logic                    busy,
   output logic                    done,
   output logic signed [W_ST-1:0]  i_d,
   output logic signed [W_ST-1:0]  i_q,
   output logic signed [W_ST-1:0]  omega,
   output logic        [W_ANG-1:0] theta
);

   // Accumulators are wide enough that no intermediate sum can wrap before saturation.
   localparam int unsigned W_ACC = W_ST + W_K;
   // Multiplier is W_K x W_ACC so that k_dt can multiply the full-width omega*i terms.
   localparam int unsigned W_P   = W_K + W_ACC;
   localparam logic [3:0]  LAST_IDX = 4'd12;

   typedef enum logic [1:0] {StIdle, StMac, StCommit} state_e;

   state_e                   state_q, state_d;
   logic [3:0]               idx_q, idx_d;
   logic                     done_q, done_d;

   // Operands latched at accept
   logic                     lock_q, lock_d;
   logic signed [W_ST-1:0]   vd_q, vd_d;
   logic signed [W_ST-1:0]   vq_q, vq_d;
   logic signed [W_ST-1:0]   tl_q, tl_d;
   logic signed [W_K-1:0]    kv_q, kv_d;
   logic signed [W_K-1:0]    kr_q, kr_d;
   logic signed [W_K-1:0]    kdt_q, kdt_d;
   logic signed [W_K-1:0]    ke_q, ke_d;
   logic signed [W_K-1:0]    kt_q, kt_d;
   logic signed [W_K-1:0]    kb_q, kb_d;
   logic signed [W_K-1:0]    kj_q, kj_d;
   logic signed [W_K-1:0]    kth_q, kth_d;

   // Partial results
   logic signed [W_ACC-1:0]  wiq_q, wiq_d;
   logic signed [W_ACC-1:0]  wid_q, wid_d;
   logic signed [W_ACC-1:0]  ad_q, ad_d;
   logic signed [W_ACC-1:0]  aq_q, aq_d;
   logic signed [W_ACC-1:0]  aw_q, aw_d;
   logic        [W_ANG-1:0]  ath_q, ath_d;

   // Plant state; held unchanged while busy, so it doubles as the latched old state
   logic signed [W_ST-1:0]   i_d_q, i_d_d;
   logic signed [W_ST-1:0]   i_q_q, i_q_d;
   logic signed [W_ST-1:0]   omega_q, omega_d;
   logic        [W_ANG-1:0]  theta_q, theta_d;

   // Shared multiplier
   logic signed [W_K-1:0]    mul_a;
   logic signed [W_ACC-1:0]  mul_b;
   logic                     shift_st;
   logic signed [W_P-1:0]    prod;
   logic signed [W_ACC-1:0]  term;

   // Commit sums
   logic signed [W_ACC-1:0]  sum_id, sum_iq, sum_om;

   // Clamp a wide sum into the signed W_ST range.
   function automatic logic signed [W_ST-1:0] sat_st(input logic signed [W_ACC-1:0] x);
      logic [W_ACC-W_ST:0] hi;
      hi = x[W_ACC-1:W_ST-1];
      if ((&hi) || !(|hi)) begin
         sat_st = x[W_ST-1:0];
      end else if (x[W_ACC-1]) begin
         sat_st = {1'b1, {(W_ST-1){1'b0}}};
      end else begin
         sat_st = {1'b0, {(W_ST-1){1'b1}}};
      end
   endfunction

   // Operand selection for the shared multiplier, keyed by MAC index.
   always_comb begin
      mul_a    = '0;
      mul_b    = '0;
      shift_st = 1'b0;
      case (idx_q)
         4'd0:  begin mul_a = W_K'(omega_q); mul_b = W_ACC'(i_q_q); shift_st = 1'b1; end
         4'd1:  begin mul_a = W_K'(omega_q); mul_b = W_ACC'(i_d_q); shift_st = 1'b1; end
         4'd2:  begin mul_a = kv_q;  mul_b = W_ACC'(vd_q);    end
         4'd3:  begin mul_a = kr_q;  mul_b = W_ACC'(i_d_q);   end
         4'd4:  begin mul_a = kdt_q; mul_b = wiq_q;           end
         4'd5:  begin mul_a = kv_q;  mul_b = W_ACC'(vq_q);    end
         4'd6:  begin mul_a = kr_q;  mul_b = W_ACC'(i_q_q);   end
         4'd7:  begin mul_a = kdt_q; mul_b = wid_q;           end
         4'd8:  begin mul_a = ke_q;  mul_b = W_ACC'(omega_q); end
         4'd9:  begin mul_a = kt_q;  mul_b = W_ACC'(i_q_q);   end
         4'd10: begin mul_a = kb_q;  mul_b = W_ACC'(omega_q); end
         4'd11: begin mul_a = kj_q;  mul_b = W_ACC'(tl_q);    end
         4'd12: begin mul_a = kth_q; mul_b = W_ACC'(omega_q); end
         default: ;
      endcase
   end

   // Product, rescaled by arithmetic shift (truncation toward -inf).
   always_comb begin
      prod = W_P'(mul_a) * W_P'(mul_b);
      term = W_ACC'(shift_st ? (prod >>> F_ST) : (prod >>> F_K));
   end

   // Candidate new state values before saturation.
   always_comb begin
      sum_id = W_ACC'(i_d_q) + ad_q;
      sum_iq = W_ACC'(i_q_q) + aq_q;
      sum_om = W_ACC'(omega_q) + aw_q;
   end

   // Sequencer: accept, MAC accumulation and commit.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      lock_d  = lock_q;
      vd_d    = vd_q;
      vq_d    = vq_q;
      tl_d    = tl_q;
      kv_d    = kv_q;
      kr_d    = kr_q;
      kdt_d   = kdt_q;
      ke_d    = ke_q;
      kt_d    = kt_q;
      kb_d    = kb_q;
      kj_d    = kj_q;
      kth_d   = kth_q;
      wiq_d   = wiq_q;
      wid_d   = wid_q;
      ad_d    = ad_q;
      aq_d    = aq_q;
      aw_d    = aw_q;
      ath_d   = ath_q;
      i_d_d   = i_d_q;
      i_q_d   = i_q_q;
      omega_d = omega_q;
      theta_d = theta_q;

      unique case (state_q)
         StIdle: begin
            if (step) begin
               lock_d  = lock;
               vd_d    = v_d;
               vq_d    = v_q;
               tl_d    = t_load;
               kv_d    = k_v;
               kr_d    = k_r;
               kdt_d   = k_dt;
               ke_d    = k_e;
               kt_d    = k_t;
               kb_d    = k_b;
               kj_d    = k_j;
               kth_d   = k_th;
               idx_d   = '0;
               state_d = StMac;
            end
         end
         StMac: begin
            case (idx_q)
               4'd0:  wiq_d = term;
               4'd1:  wid_d = term;
               4'd2:  ad_d  = term;
               4'd3:  ad_d  = ad_q - term;
               4'd4:  ad_d  = ad_q + term;
               4'd5:  aq_d  = term;
               4'd6:  aq_d  = aq_q - term;
               4'd7:  aq_d  = aq_q - term;
               4'd8:  aq_d  = aq_q - term;
               4'd9:  aw_d  = term;
               4'd10: aw_d  = aw_q - term;
               4'd11: aw_d  = aw_q - term;
               4'd12: ath_d = term[W_ANG-1:0];
               default: ;
            endcase
            if (idx_q == LAST_IDX) begin
               state_d = StCommit;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         StCommit: begin
            i_d_d = sat_st(sum_id);
            i_q_d = sat_st(sum_iq);
            // Locked rotor: speed pinned to zero, angle frozen
            if (lock_q) begin
               omega_d = '0;
            end else begin
               omega_d = sat_st(sum_om);
               theta_d = theta_q + ath_q;
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset discards any step in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         done_q  <= 1'b0;
         lock_q  <= 1'b0;
         vd_q    <= '0;
         vq_q    <= '0;
         tl_q    <= '0;
         kv_q    <= '0;
         kr_q    <= '0;
         kdt_q   <= '0;
         ke_q    <= '0;
         kt_q    <= '0;
         kb_q    <= '0;
         kj_q    <= '0;
         kth_q   <= '0;
         wiq_q   <= '0;
         wid_q   <= '0;
         ad_q    <= '0;
         aq_q    <= '0;
         aw_q    <= '0;
         ath_q   <= '0;
         i_d_q   <= '0;
         i_q_q   <= '0;
         omega_q <= '0;
         theta_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         lock_q  <= lock_d;
         vd_q    <= vd_d;
         vq_q    <= vq_d;
         tl_q    <= tl_d;
         kv_q    <= kv_d;
         kr_q    <= kr_d;
         kdt_q   <= kdt_d;
         ke_q    <= ke_d;
         kt_q    <= kt_d;
         kb_q    <= kb_d;
         kj_q    <= kj_d;
         kth_q   <= kth_d;
         wiq_q   <= wiq_d;
         wid_q   <= wid_d;
         ad_q    <= ad_d;
         aq_q    <= aq_d;
         aw_q    <= aw_d;
         ath_q   <= ath_d;
         i_d_q   <= i_d_d;
         i_q_q   <= i_q_d;
         omega_q <= omega_d;
         theta_q <= theta_d;
      end
   end

   assign busy  = (state_q != StIdle);
   assign done  = done_q;
   assign i_d   = i_d_q;
   assign i_q   = i_q_q;
   assign omega = omega_q;
   assign theta = theta_q;

endmodule

// File: tb/tb_pmsm_dq_plant.sv
// Self-checking bench for pmsm_dq_plant: directed cases plus randomized traffic
// compared every cycle against an equation-level model of one Euler step.
module tb_pmsm_dq_plant;

   localparam int W_ST  = 16;
   localparam int F_ST  = 12;
   localparam int W_K   = 18;
   localparam int F_K   = 16;
   localparam int W_ANG = 16;
   localparam int LAT   = 14;
   localparam longint SMAX = (64'sd1 <<< (W_ST - 1)) - 1;
   localparam longint SMIN = -(64'sd1 <<< (W_ST - 1));
   localparam longint AMASK = (64'sd1 <<< W_ANG) - 1;

   localparam int T3_IQ [3] = '{200, 200, 200};
   localparam int T3_OM [3] = '{0, 200, 200};
   localparam int T3_TH [3] = '{0, 0, 200};
   localparam int T5_TH [5] = '{0, 0, 30000, 60000, 24464};

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    step;
   logic                    lock;
   logic signed [W_ST-1:0]  v_d, v_q, t_load;
   logic signed [W_K-1:0]   k_v, k_r, k_dt, k_e, k_t, k_b, k_j, k_th;
   logic                    busy, done;
   logic signed [W_ST-1:0]  i_d, i_q, omega;
   logic        [W_ANG-1:0] theta;

   int n_cmp = 0;
   int n_bad = 0;

   pmsm_dq_plant #(
      .W_ST (W_ST),
      .F_ST (F_ST),
      .W_K  (W_K),
      .F_K  (F_K),
      .W_ANG(W_ANG)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .step  (step),
      .lock  (lock),
      .v_d   (v_d),
      .v_q   (v_q),
      .t_load(t_load),
      .k_v   (k_v),
      .k_r   (k_r),
      .k_dt  (k_dt),
      .k_e   (k_e),
      .k_t   (k_t),
      .k_b   (k_b),
      .k_j   (k_j),
      .k_th  (k_th),
      .busy  (busy),
      .done  (done),
      .i_d   (i_d),
      .i_q   (i_q),
      .omega (omega),
      .theta (theta)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   longint m_id = 0, m_iq = 0, m_om = 0, m_th = 0;
   longint p_id = 0, p_iq = 0, p_om = 0, p_th = 0;
   int     m_cnt = 0;
   bit     m_done = 1'b0;

   function automatic longint sat(input longint x);
      if (x > SMAX) return SMAX;
      if (x < SMIN) return SMIN;
      return x;
   endfunction

   // New state from the step equations, using the inputs present at accept.
   task automatic model_accept();
      longint kv = k_v, kr = k_r, kdt = k_dt, ke = k_e;
      longint kt = k_t, kb = k_b, kj = k_j, kth = k_th;
      longint vd = v_d, vq = v_q, tl = t_load;
      longint wiq, wid, ad, aq, aw, ath;
      wiq = (m_om * m_iq) >>> F_ST;
      wid = (m_om * m_id) >>> F_ST;
      ad  = ((kv * vd) >>> F_K) - ((kr * m_id) >>> F_K) + ((kdt * wiq) >>> F_K);
      aq  = ((kv * vq) >>> F_K) - ((kr * m_iq) >>> F_K) - ((kdt * wid) >>> F_K)
            - ((ke * m_om) >>> F_K);
      aw  = ((kt * m_iq) >>> F_K) - ((kb * m_om) >>> F_K) - ((kj * tl) >>> F_K);
      ath = (kth * m_om) >>> F_K;
      p_id = sat(m_id + ad);
      p_iq = sat(m_iq + aq);
      if (lock) begin
         p_om = 0;
         p_th = m_th;
      end else begin
         p_om = sat(m_om + aw);
         p_th = (m_th + ath) & AMASK;
      end
   endtask

   // Protocol model: a step occupies LAT cycles, results appear with done.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_id = 0; m_iq = 0; m_om = 0; m_th = 0;
         m_cnt = 0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_cnt == 0) begin
            if (step) begin
               model_accept();
               m_cnt = LAT;
            end
         end else begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_id = p_id; m_iq = p_iq; m_om = p_om; m_th = p_th;
               m_done = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      check("busy", longint'(busy), longint'(m_cnt != 0));
      check("done", longint'(done), longint'(m_done));
      check("i_d", i_d, m_id);
      check("i_q", i_q, m_iq);
      check("omega", omega, m_om);
      check("theta", theta, m_th);
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_k(input logic signed [W_K-1:0] kv, kr, kdt, ke, kt, kb, kj, kth);
      k_v = kv; k_r = kr; k_dt = kdt; k_e = ke; k_t = kt; k_b = kb; k_j = kj; k_th = kth;
   endtask

   // Issue one step and return cycles from accept edge to done being visible.
   task automatic do_step(output int lat);
      @(posedge clk); #2 step = 1'b1;
      @(posedge clk); #2 step = 1'b0;
      lat = 0;
      while (lat < 30) begin
         @(posedge clk);
         lat++;
         #1;
         if (done) break;
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #3 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
   endtask

   function automatic logic signed [W_K-1:0] rand_k();
      int t;
      if ($urandom_range(0, 4) == 0) return W_K'($urandom);
      t = int'($urandom_range(0, 32767)) - 16384;
      return W_K'(t);
   endfunction

   localparam logic signed [W_K-1:0] ONE  = 18'sh10000;
   localparam logic signed [W_K-1:0] HALF = 18'sh08000;

   initial begin
      int lat;
      int ndone;
      rst = 1'b1; step = 1'b0; lock = 1'b0;
      v_d = '0; v_q = '0; t_load = '0;
      set_k('0, '0, '0, '0, '0, '0, '0, '0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_id", i_d, 0);
      check("rst_theta", theta, 0);

      // Half-gain voltage input on d axis
      set_k(HALF, '0, '0, '0, '0, '0, '0, '0);
      v_d = 16'sd1000;
      do_step(lat);
      check("t2_latency", lat, 14);
      check("t2_id", i_d, 500);
      check("t2_model_id", m_id, 500);
      check("t2_iq", i_q, 0);
      check("t2_omega", omega, 0);
      check("t2_theta", theta, 0);

      // Reset mid-MAC clears everything at once
      @(posedge clk); #2 step = 1'b1;
      @(posedge clk); #2 step = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("t1_busy", busy, 0);
      check("t1_done", done, 0);
      check("t1_id", i_d, 0);
      check("t1_iq", i_q, 0);
      check("t1_omega", omega, 0);
      check("t1_theta", theta, 0);
      @(posedge clk); #2 rst = 1'b0;
      do_step(lat);
      check("t1_relat", lat, 14);
      check("t1_reid", i_d, 500);

      // Saturation of i_d in both directions
      pulse_reset();
      set_k(ONE, '0, '0, '0, '0, '0, '0, '0);
      v_d = 16'sd32767;
      repeat (3) do_step(lat);
      check("t4_id_pos", i_d, 32767);
      v_d = -16'sd32768;
      repeat (3) do_step(lat);
      check("t4_id_neg", i_d, -32768);
      check("t4_model_neg", m_id, -32768);

      // q-axis build-up feeding speed and angle
      pulse_reset();
      set_k(ONE, ONE, '0, '0, ONE, ONE, '0, ONE);
      v_d = '0; v_q = 16'sd200;
      for (int s = 0; s < 3; s++) begin
         do_step(lat);
         check("t3_iq", i_q, T3_IQ[s]);
         check("t3_omega", omega, T3_OM[s]);
         check("t3_theta", theta, T3_TH[s]);
      end
      check("t3_model_om", m_om, 200);

      // Locked rotor, with a second step request and input changes while busy
      lock = 1'b1;
      @(posedge clk); #2 step = 1'b1;
      @(posedge clk); #2 step = 1'b0;
      lock = 1'b0;
      repeat (3) @(posedge clk);
      #2 step = 1'b1; v_q = 16'sd5000;
      @(posedge clk); #2 step = 1'b0;
      ndone = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("t6_done_count", ndone, 1);
      check("t6_omega", omega, 0);
      check("t6_theta", theta, 200);
      check("t6_iq", i_q, 200);

      // Angle wrap
      pulse_reset();
      set_k(ONE, ONE, '0, '0, ONE, ONE, '0, ONE);
      v_q = 16'sd30000;
      for (int s = 0; s < 5; s++) begin
         do_step(lat);
         check("t5_theta", theta, T5_TH[s]);
      end
      check("t5_model_th", m_th, 24464);

      // Randomized traffic, inputs changing every cycle, occasional resets
      pulse_reset();
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         rst    = ($urandom_range(0, 599) == 0);
         step   = ($urandom_range(0, 2) != 0);
         lock   = ($urandom_range(0, 5) == 0);
         v_d    = W_ST'($urandom);
         v_q    = W_ST'($urandom);
         t_load = W_ST'($urandom);
         set_k(rand_k(), rand_k(), rand_k(), rand_k(),
               rand_k(), rand_k(), rand_k(), rand_k());
      end
      @(posedge clk); #2 rst = 1'b0; step = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
